// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the word-indexed instruction
// memory through a ready handshake, and holds one fetched entry for decode.
// Redirects override everything except BOOT. A misaligned or out-of-range PC
// produces an AdEL fault entry and parks the unit in HALT until the next redirect.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'h0000_3000,
    parameter logic [31:0] ADDR_START = 32'h0000_3000,
    parameter int unsigned WORDNUM    = 4096,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_addr,
    output logic        im_ce,
    output logic        im_re,
    output logic        im_we,
    output logic [3:0]  im_be,
    output logic [31:0] im_din,
    input  logic [31:0] im_dout,
    input  logic        im_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_exc,
    output logic [4:0]  id_exccode
);

    // One past the last valid byte address of the memory.
    localparam logic [31:0] ADDR_END = ADDR_START + 32'(WORDNUM * 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] bpc_q, bpc_d;
    logic        exc_q, exc_d;

    logic        fault;
    logic        slot_free;
    logic [31:0] pc_off;

    // Address fault, buffer availability and the bus request, all from registered state.
    always_comb begin
        fault     = (pc_q[1:0] != 2'b00) || (pc_q < ADDR_START) || (pc_q >= ADDR_END);
        slot_free = !valid_q || id_ready;
        im_re     = (state_q == FETCH) && !fault && slot_free && !redir_valid;
        pc_off    = pc_q - ADDR_START;
        im_addr   = {2'b00, pc_off[31:2]};
        im_ce     = im_re;
        im_we     = 1'b0;
        im_be     = 4'b1111;
        im_din    = 32'h0;
    end

    // Next-state: redirect wins, then a completed fetch, then a fault entry.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        bpc_d   = bpc_q;
        exc_d   = exc_q;
        if (state_q == BOOT) begin
            state_d = FETCH;
        end else if (redir_valid) begin
            // Any in-flight data is dropped and the buffer flushed.
            pc_d    = redir_pc;
            valid_d = 1'b0;
            state_d = FETCH;
        end else begin
            if (valid_q && id_ready) begin
                valid_d = 1'b0;
            end
            if (im_re && im_ready) begin
                instr_d = im_dout;
                bpc_d   = pc_q;
                exc_d   = 1'b0;
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
            end else if ((state_q == FETCH) && fault && slot_free) begin
                instr_d = 32'h0;
                bpc_d   = pc_q;
                exc_d   = 1'b1;
                valid_d = 1'b1;
                state_d = HALT;
            end
        end
    end

    // State, PC and output buffer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            bpc_q   <= PC_RESET;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            bpc_q   <= bpc_d;
            exc_q   <= exc_d;
        end
    end

    assign id_valid   = valid_q;
    assign id_instr   = instr_q;
    assign id_pc      = bpc_q;
    assign id_exc     = exc_q;
    assign id_exccode = exc_q ? EXC_ADEL : 5'd0;

endmodule
